// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Register file for the mini MIPS datapath. It has two combinational read
//   ports and an optional same-cycle write-to-read bypass. Register 0 can be
//   hard-wired to zero. A per-register pending bit lets decode stall on
//   operands whose producer has not yet written back.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   RegWrite         write-back enable, with WriteRegister / WriteData
//   RegReadA/B       read indices; ReadDataA/B and BusyA/B are combinational
//   Reserve          issue-stage reservation of ReserveRegister
//   PendingCount     registered count of pending registers
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] RegReadA,
  input  logic [ADDR_W-1:0] RegReadB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  output logic              BusyA,
  output logic              BusyB,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, res_en, inc, dec;

  // Writes and reservations aimed at a hard-wired zero register are dropped.
  assign wr_en  = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));
  assign res_en = Reserve  && !((ZERO_REG != 0) && (ReserveRegister == '0));

  // The count is tracked incrementally rather than by popcount. A reserve
  // that hits the write index in the same cycle means the register stays
  // pending, so that write must not decrement the count.
  assign inc = res_en && !pend_q[ReserveRegister];
  assign dec = wr_en && pend_q[WriteRegister] &&
               !(res_en && (ReserveRegister == WriteRegister));

  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[WriteRegister]   = 1'b0;
    if (res_en) pend_d[ReserveRegister] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) mem_q[WriteRegister] <= WriteData;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign PendingCount = cnt_q;

  always_comb begin
    ReadDataA = mem_q[RegReadA];
    BusyA     = pend_q[RegReadA];
    if ((ZERO_REG != 0) && (RegReadA == '0)) begin
      ReadDataA = '0;
      BusyA     = 1'b0;
    end else if ((BYPASS != 0) && RegWrite && (WriteRegister == RegReadA)) begin
      ReadDataA = WriteData;
      BusyA     = 1'b0;
    end
  end

  always_comb begin
    ReadDataB = mem_q[RegReadB];
    BusyB     = pend_q[RegReadB];
    if ((ZERO_REG != 0) && (RegReadB == '0)) begin
      ReadDataB = '0;
      BusyB     = 1'b0;
    end else if ((BYPASS != 0) && RegWrite && (WriteRegister == RegReadB)) begin
      ReadDataB = WriteData;
      BusyB     = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // shared stimulus for u0 (bypass, no zero reg) and u1 (no bypass, zero reg)
  logic        we, res;
  logic [2:0]  wi, ra, rb, rr;
  logic [31:0] wd;
  // stimulus for u2 (ADDR_W=4, DATA_W=16)
  logic        we2, res2;
  logic [3:0]  wi2, ra2, rb2, rr2;
  logic [15:0] wd2;

  logic [31:0] rda0, rdb0, rda1, rdb1;
  logic [15:0] rda2, rdb2;
  logic        ba0, bb0, ba1, bb1, ba2, bb2;
  logic [3:0]  pc0, pc1;
  logic [4:0]  pc2;

  reg_file_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteRegister(wi), .WriteData(wd),
    .RegReadA(ra), .RegReadB(rb), .ReadDataA(rda0), .ReadDataB(rdb0),
    .Reserve(res), .ReserveRegister(rr), .BusyA(ba0), .BusyB(bb0), .PendingCount(pc0));

  reg_file_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteRegister(wi), .WriteData(wd),
    .RegReadA(ra), .RegReadB(rb), .ReadDataA(rda1), .ReadDataB(rdb1),
    .Reserve(res), .ReserveRegister(rr), .BusyA(ba1), .BusyB(bb1), .PendingCount(pc1));

  reg_file_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .RegWrite(we2), .WriteRegister(wi2), .WriteData(wd2),
    .RegReadA(ra2), .RegReadB(rb2), .ReadDataA(rda2), .ReadDataB(rdb2),
    .Reserve(res2), .ReserveRegister(rr2), .BusyA(ba2), .BusyB(bb2), .PendingCount(pc2));

  // reference model
  logic [31:0] m_mem  [3][16];
  bit          m_pend [3][16];
  int          zr  [3] = '{0, 1, 0};
  int          bp  [3] = '{1, 0, 1};
  int          dep [3] = '{8, 8, 16};

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t  q_exp [$];
  string q_tag [$];
  string phase;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int i, input int p);
    logic [31:0] r;
    r = '0;
    case (i)
      0: case (p) 0: r = rda0; 1: r = rdb0; 2: r = {31'h0, ba0}; 3: r = {31'h0, bb0};
                  default: r = {28'h0, pc0}; endcase
      1: case (p) 0: r = rda1; 1: r = rdb1; 2: r = {31'h0, ba1}; 3: r = {31'h0, bb1};
                  default: r = {28'h0, pc1}; endcase
      default: case (p) 0: r = {16'h0, rda2}; 1: r = {16'h0, rdb2}; 2: r = {31'h0, ba2};
                  3: r = {31'h0, bb2}; default: r = {27'h0, pc2}; endcase
    endcase
    return r;
  endfunction

  task automatic get_in(input int i, output bit w, output int wix, output logic [31:0] wdat,
                        output int a, output int b, output bit r, output int rix);
    if (i < 2) begin
      w = we; wix = int'(wi); wdat = wd; a = int'(ra); b = int'(rb); r = res; rix = int'(rr);
    end else begin
      w = we2; wix = int'(wi2); wdat = {16'h0, wd2}; a = int'(ra2); b = int'(rb2);
      r = res2; rix = int'(rr2);
    end
  endtask

  task automatic exp_rd(input int i, input int idx, input bit w, input int wix,
                        input logic [31:0] wdat, output logic [31:0] d, output logic [31:0] bz);
    if (zr[i] != 0 && idx == 0) begin
      d = '0; bz = '0;
    end else if (bp[i] != 0 && w && wix == idx) begin
      d = wdat; bz = '0;
    end else begin
      d = m_mem[i][idx]; bz = {31'h0, m_pend[i][idx]};
    end
  endtask

  task automatic push_exp();
    bit w, r;
    int wix, a, b, rix, cnt;
    logic [31:0] wdat, d, bz;
    string pn [5] = '{"rdA", "rdB", "bsyA", "bsyB", "cnt"};
    for (int i = 0; i < 3; i++) begin
      get_in(i, w, wix, wdat, a, b, r, rix);
      exp_rd(i, a, w, wix, wdat, d, bz);
      q_exp.push_back('{i, 0, d});  q_exp.push_back('{i, 2, bz});
      exp_rd(i, b, w, wix, wdat, d, bz);
      q_exp.push_back('{i, 1, d});  q_exp.push_back('{i, 3, bz});
      cnt = 0;
      for (int k = 0; k < dep[i]; k++) cnt += int'(m_pend[i][k]);
      q_exp.push_back('{i, 4, 32'(cnt)});
      q_tag.push_back($sformatf("u%0d_%s_%s", i, pn[0], phase));
      q_tag.push_back($sformatf("u%0d_%s_%s", i, pn[2], phase));
      q_tag.push_back($sformatf("u%0d_%s_%s", i, pn[1], phase));
      q_tag.push_back($sformatf("u%0d_%s_%s", i, pn[3], phase));
      q_tag.push_back($sformatf("u%0d_%s_%s", i, pn[4], phase));
    end
  endtask

  task automatic pop_cmp();
    exp_t  e;
    string t;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      chk(t, obs(e.inst, e.port), e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) begin
        m_mem[i][k] = '0;
        m_pend[i][k] = 1'b0;
      end
  endtask

  task automatic model_update();
    bit w, r;
    int wix, a, b, rix;
    logic [31:0] wdat;
    for (int i = 0; i < 3; i++) begin
      get_in(i, w, wix, wdat, a, b, r, rix);
      if (w && !(zr[i] != 0 && wix == 0)) begin
        m_mem[i][wix]  = wdat;
        m_pend[i][wix] = 1'b0;
      end
      if (r && !(zr[i] != 0 && rix == 0)) m_pend[i][rix] = 1'b1;
    end
  endtask

  // inputs are set just after a rising edge; outputs checked on the falling edge
  task automatic cyc();
    push_exp();
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic idle();
    we = 0; wi = 0; wd = '0; ra = 0; rb = 0; res = 0; rr = 0;
    we2 = 0; wi2 = 0; wd2 = '0; ra2 = 0; rb2 = 0; res2 = 0; rr2 = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #3;
    phase = "rst0";
    push_exp(); pop_cmp();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // write r3, read it, then async reset with no clock edge
    phase = "wr3";  we = 1; wi = 3; wd = 32'h1234; cyc();
    idle(); phase = "rd3"; ra = 3; rb = 3; cyc();
    we = 1; wi = 6; wd = 32'h55; res = 1; rr = 1;
    #2; rst_n = 1'b0; model_reset(); #1;
    phase = "async_rst"; push_exp(); pop_cmp();
    phase = "in_rst"; cyc();
    rst_n = 1'b1;
    idle(); phase = "post_rst"; ra = 6; rb = 3; ra2 = 1; cyc();

    // bypass
    phase = "byp"; we = 1; wi = 5; wd = 32'hDEADBEEF; ra = 5; rb = 5; cyc();
    idle(); phase = "byp_next"; ra = 5; cyc();

    // scoreboard
    phase = "rsv2"; res = 1; rr = 2; cyc();
    idle(); phase = "busy2"; rb = 2; cyc();
    phase = "wb2"; we = 1; wi = 2; wd = 32'h7; rb = 2; cyc();
    idle(); phase = "clr2"; rb = 2; cyc();

    // reserve and write to the same index
    phase = "col4"; res = 1; rr = 4; we = 1; wi = 4; wd = 32'hA4; ra = 4; cyc();
    idle(); phase = "col4_n"; ra = 4; cyc();
    phase = "col4p"; res = 1; rr = 4; we = 1; wi = 4; wd = 32'hB4; ra = 4; cyc();
    idle(); phase = "col4p_n"; ra = 4; rb = 4; cyc();
    phase = "wb4"; we = 1; wi = 4; wd = 32'h0; cyc();

    // zero register
    phase = "zr"; we = 1; wi = 0; wd = 32'hFF; res = 1; rr = 0; ra = 0; cyc();
    idle(); phase = "zr_n"; ra = 0; rb = 0; cyc();
    phase = "zr_clr"; we = 1; wi = 0; wd = 32'h0; cyc();

    // random traffic on all instances
    phase = "rnd";
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1)); wi = 3'($urandom_range(0, 7)); wd = $urandom;
      res = 1'($urandom_range(0, 1)); rr = 3'($urandom_range(0, 7));
      ra  = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
      we2 = 1'($urandom_range(0, 1)); wi2 = 4'($urandom_range(0, 15)); wd2 = 16'($urandom);
      res2 = 1'($urandom_range(0, 1)); rr2 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15)); rb2 = 4'($urandom_range(0, 15));
      cyc();
    end

    // fill and drain the 16-entry instance
    idle(); phase = "clr16";
    for (int k = 0; k < 16; k++) begin we2 = 1; wi2 = 4'(k); wd2 = 16'(k); cyc(); end
    idle(); phase = "rsv16";
    for (int k = 0; k < 16; k++) begin res2 = 1; rr2 = 4'(k); ra2 = 4'(k); cyc(); end
    idle(); phase = "full16"; ra2 = 15; cyc();
    phase = "drain16";
    for (int k = 0; k < 16; k++) begin
      we2 = 1; wi2 = 4'(k); wd2 = 16'(16'hA000 + k); ra2 = 4'(k); rb2 = 4'((k + 1) % 16); cyc();
    end
    idle(); phase = "nowrap";
    for (int k = 0; k < 3; k++) begin we2 = 1; wi2 = 4'(k); wd2 = 16'h5; cyc(); end
    idle(); phase = "end"; cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
